// File: rtl/axi_xbar_pkg.sv
// ============================================================================
// Module   : axi_xbar_pkg
// Purpose  : Shared definitions for the AXI crossbar: slave address map,
//            slave count and the per-slave arbiter state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_xbar_pkg;

    // Slave address map (inclusive ranges)
    localparam logic [31:0] S0_MIN = 32'h0000_0000;
    localparam logic [31:0] S0_MAX = 32'h0000_3FFF;
    localparam logic [31:0] S1_MIN = 32'h0001_0000;
    localparam logic [31:0] S1_MAX = 32'h0001_FFFF;
    localparam logic [31:0] S2_MIN = 32'h0002_0000;
    localparam logic [31:0] S2_MAX = 32'h0002_FFFF;
    localparam logic [31:0] S3_MIN = 32'h1000_0000;
    localparam logic [31:0] S3_MAX = 32'h1000_03FF;
    localparam logic [31:0] S4_MIN = 32'h1001_0000;
    localparam logic [31:0] S4_MAX = 32'h1001_03FF;
    localparam logic [31:0] S5_MIN = 32'h2000_0000;
    localparam logic [31:0] S5_MAX = 32'h207F_FFFF;

    localparam int NUM_SLAVES = 6;

    // Arbiter states: no owner, owner waiting for address handshake,
    // owner waiting for the response to complete.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage : axi_xbar_pkg

`default_nettype wire

// File: rtl/axi_slave_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating-priority picker. Selects the first set
//            request bit at or above ptr_i, wrapping modulo NUM_M.
// Ports    : req_i    [NUM_M-1:0]  request vector
//            ptr_i    [IDX_W-1:0]  highest-priority index (must be < NUM_M)
//            valid_o               at least one request present
//            idx_o    [IDX_W-1:0]  selected index (0 when !valid_o)
//            onehot_o [NUM_M-1:0]  one-hot form of idx_o (0 when !valid_o)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [NUM_M-1:0] onehot_o
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [IDX_W:0] w_cand;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (w_cand >= (IDX_W + 1)'(NUM_M)) begin
                w_cand = w_cand - (IDX_W + 1)'(NUM_M);
            end
            if (!valid_o && req_i[w_cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = w_cand[IDX_W-1:0];
            end
        end
        onehot_o = valid_o ? (NUM_M'(1) << idx_o) : '0;
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/axi_slave_arbiter.sv
// ============================================================================
// Module   : axi_slave_arbiter
// Purpose  : Per-slave AXI address-channel arbiter. Grants one master with
//            round-robin priority and holds the grant from the address
//            handshake until the response completes, so the slave sees one
//            outstanding transaction. A watchdog frees a stuck slave.
// Ports    : ACLK                     clock
//            ARESETn                  synchronous active-low reset
//            req_i       [NUM_M-1:0]  per-master request (select & AxVALID)
//            addr_hs_i                AxVALID & AxREADY at this slave
//            resp_done_i              last read beat / write response accepted
//            grant_o     [NUM_M-1:0]  registered one-hot grant
//            grant_idx_o [IDX_W-1:0]  granted master index (valid when busy)
//            busy_o                   slave owned by a master
//            timeout_o                one-cycle pulse on watchdog release
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_slave_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int NUM_M          = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = $clog2(NUM_M)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [NUM_M-1:0] req_i,
    input  logic             addr_hs_i,
    input  logic             resp_done_i,
    output logic [NUM_M-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    // With the watchdog off the counter is a single unused bit.
    localparam int CNT_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_M - 1);

    arb_state_t       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             to_q,    to_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [NUM_M-1:0] pick_onehot;

    rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                // Priority rotates past the winner only once it has actually
                // issued its address, so a stalled master keeps its turn.
                if (addr_hs_i) begin
                    state_d = RESP;
                    ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end
            end

            RESP: begin
                // A real completion takes precedence over a simultaneous expiry.
                if (resp_done_i) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (WD_EN && (cnt_q == CNT_EXP)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    to_d    = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = to_q;

endmodule : axi_slave_arbiter

`default_nettype wire

// File: tb/tb_axi_slave_arbiter.sv
// ============================================================================
// Module   : tb_axi_slave_arbiter
// Purpose  : Self-checking bench for axi_slave_arbiter (NUM_M=2,
//            TIMEOUT_CYCLES=8). Stimulus pushes expected grant / release /
//            timeout events with their cycle; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_slave_arbiter;

    localparam int NUM_M   = 2;
    localparam int TO_CYC  = 8;
    localparam int EV_GNT  = 0;
    localparam int EV_REL  = 1;
    localparam int EV_TO   = 2;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic [NUM_M-1:0] req_i;
    logic             addr_hs_i;
    logic             resp_done_i;
    logic [NUM_M-1:0] grant_o;
    logic [0:0]       grant_idx_o;
    logic             busy_o;
    logic             timeout_o;

    axi_slave_arbiter #(
        .NUM_M          (NUM_M),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .req_i       (req_i),
        .addr_hs_i   (addr_hs_i),
        .resp_done_i (resp_done_i),
        .grant_o     (grant_o),
        .grant_idx_o (grant_idx_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [1:0] val;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad   = 0;
    bit         mon_en = 1'b0;
    logic [1:0] prev_g = '0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [1:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, expected none",
                     kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind",  kind,     e.kind);
            chk("event_value", int'(val), int'(e.val));
            chk("event_cycle", cyc,      e.at);
        end
    endtask

    // Monitor: invariants every cycle, events whenever the DUT shows one.
    always @(negedge ACLK) begin
        if (mon_en) begin
            chk("inv_onehot0", int'($onehot0(grant_o)), 1);
            chk("inv_busy_grant", int'(grant_o != '0), int'(busy_o));
            if (busy_o) chk("inv_idx", int'(grant_o[grant_idx_o]), 1);
            if (grant_o == '0 && prev_g != '0) observe(EV_REL, 2'b00);
            if (timeout_o) observe(EV_TO, 2'b00);
            if (grant_o != '0 && grant_o != prev_g) observe(EV_GNT, grant_o);
            prev_g = grant_o;
        end
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge ACLK);
    endtask

    // One transaction, cycles relative to c0 (the cycle req is presented).
    // dn < 0: no response, the watchdog must release. Returns in the IDLE cycle.
    task automatic txn(input logic [1:0] rq, input logic [1:0] g, input int hs, input int dn);
        int c0;
        c0    = cyc;
        req_i = rq;
        push(EV_GNT, g, c0 + 1);
        goto(c0 + hs);
        addr_hs_i = 1'b1;
        @(negedge ACLK);
        addr_hs_i = 1'b0;
        if (dn < 0) begin
            push(EV_REL, 2'b00, c0 + hs + TO_CYC + 1);
            push(EV_TO,  2'b00, c0 + hs + TO_CYC + 1);
            goto(c0 + hs + TO_CYC + 1);
        end else begin
            push(EV_REL, 2'b00, c0 + dn + 1);
            goto(c0 + dn);
            resp_done_i = 1'b1;
            @(negedge ACLK);
            resp_done_i = 1'b0;
        end
    endtask

    // Reset while in RESP, then check priority restarts at master 0.
    task automatic resp_reset(input logic [1:0] rq, input logic [1:0] g);
        int c0;
        c0    = cyc;
        req_i = rq;
        push(EV_GNT, g, c0 + 1);
        goto(c0 + 2);
        addr_hs_i = 1'b1;
        req_i     = 2'b00;
        @(negedge ACLK);
        addr_hs_i = 1'b0;
        goto(c0 + 4);
        ARESETn = 1'b0;
        push(EV_REL, 2'b00, c0 + 5);
        goto(c0 + 5);
        chk("midrst_grant", int'(grant_o), 0);
        chk("midrst_idx",   int'(grant_idx_o), 0);
        chk("midrst_busy",  int'(busy_o), 0);
        chk("midrst_to",    int'(timeout_o), 0);
        ARESETn = 1'b1;
        txn(2'b11, 2'b01, 2, 4);
        req_i = 2'b00;
    endtask

    initial begin
        int c0;
        ARESETn     = 1'b0;
        req_i       = 2'b11;
        addr_hs_i   = 1'b0;
        resp_done_i = 1'b0;

        // Reset held for two edges with requests present
        @(negedge ACLK);
        @(negedge ACLK);
        chk("rst_grant", int'(grant_o), 0);
        chk("rst_idx",   int'(grant_idx_o), 0);
        chk("rst_busy",  int'(busy_o), 0);
        chk("rst_to",    int'(timeout_o), 0);
        mon_en  = 1'b1;
        ARESETn = 1'b1;

        // Fairness: requests held, grants alternate starting at master 0
        txn(2'b11, 2'b01, 2, 4);
        txn(2'b11, 2'b10, 2, 4);
        txn(2'b11, 2'b01, 2, 4);
        txn(2'b11, 2'b10, 2, 4);

        // Single transaction: grant @1, handshake @3, done @6, release @7
        txn(2'b01, 2'b01, 3, 6);
        req_i = 2'b00;
        @(negedge ACLK);

        // Held grant; resp_done in IDLE and ADDR is ignored
        c0          = cyc;
        req_i       = 2'b01;
        resp_done_i = 1'b1;
        push(EV_GNT, 2'b01, c0 + 1);
        @(negedge ACLK);
        req_i       = 2'b10;
        resp_done_i = 1'b1;
        @(negedge ACLK);
        resp_done_i = 1'b0;
        chk("held_grant_a", int'(grant_o), 1);
        chk("held_busy_a",  int'(busy_o), 1);
        goto(c0 + 3);
        chk("held_grant_b", int'(grant_o), 1);
        addr_hs_i = 1'b1;
        req_i     = 2'b00;
        @(negedge ACLK);
        addr_hs_i = 1'b0;
        chk("held_busy_resp", int'(busy_o), 1);
        chk("held_grant_resp", int'(grant_o), 1);
        goto(c0 + 6);
        push(EV_REL, 2'b00, c0 + 7);
        resp_done_i = 1'b1;
        @(negedge ACLK);
        resp_done_i = 1'b0;

        // Watchdog release of master 1, then master 0 wins with both requesting;
        // second transaction completes exactly on the expiry cycle.
        txn(2'b10, 2'b10, 2, -1);
        txn(2'b11, 2'b01, 2, 2 + TO_CYC);
        req_i = 2'b00;
        @(negedge ACLK);

        // Reset in RESP: once while master 1 holds, once while master 0 holds
        resp_reset(2'b10, 2'b10);
        @(negedge ACLK);
        resp_reset(2'b01, 2'b01);

        repeat (4) @(negedge ACLK);
        chk("events_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule : tb_axi_slave_arbiter

`default_nettype wire

// File: doc/axi_slave_arbiter.md
Name: axi_slave_arbiter

Overview:
- Per-slave address-channel arbiter for the AXI crossbar. One instance sits in front of each slave port, on both the AR and the AW channel.
- It takes per-master requests (the decoder slave-select bit ANDed with the master's AxVALID) and grants exactly one master with rotating (round-robin) priority.
- The grant is held through the address handshake and until the transaction's response completes, so each slave has one outstanding transaction.
- A watchdog releases the grant if the slave never completes the response.

Parameters:
- NUM_M, 2, number of masters arbitrated (>=2).
- TIMEOUT_CYCLES, 1024, maximum cycles in RESP before forced release; 0 disables the watchdog.
- IDX_W, $clog2(NUM_M), width of grant index (derived; not overridden).

Ports:
- ACLK  in  1  clock; all state updates on rising edge.
- ARESETn  in  1  synchronous, active-low reset.
- req_i  in  NUM_M  per-master request; bit m = master m targets this slave with AxVALID high.
- addr_hs_i  in  1  address handshake (AxVALID & AxREADY) completed at this slave port.
- resp_done_i  in  1  response complete: RVALID&RREADY&RLAST for read, BVALID&BREADY for write.
- grant_o  out  NUM_M  one-hot grant, registered.
- grant_idx_o  out  IDX_W  binary index of the granted master; valid when busy_o=1.
- busy_o  out  1  a master holds the slave (state != IDLE).
- timeout_o  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset: ARESETn sampled low at a rising edge gives:
  - state=IDLE, grant_o=0, grant_idx_o=0, busy_o=0, timeout_o=0;
  - rr_ptr=0, timeout counter=0.
  - Reset mid-transaction aborts it silently; there is no timeout pulse.
- States: IDLE, ADDR, RESP (enum in package).
- IDLE:
  - Requester selection: if req_i!=0, select the first set bit at or after rr_ptr, searching upward with wrap modulo NUM_M.
  - Next edge: grant_o=onehot(sel), grant_idx_o=sel, state=ADDR.
  - Latency from req_i rising to grant_o rising is 1 cycle.
  - addr_hs_i and resp_done_i are ignored in IDLE.
- ADDR:
  - Grant is held.
  - On addr_hs_i=1: state=RESP, rr_ptr=(grant_idx_o+1) mod NUM_M, counter cleared.
  - Changes on req_i are ignored; the grant is never revoked before the handshake.
  - resp_done_i is ignored.
- RESP:
  - Grant is held; the counter increments each cycle.
  - On resp_done_i=1: the next edge gives state=IDLE, grant_o=0, busy_o=0.
  - A new grant can appear at the earliest 2 cycles after resp_done_i: 1 cycle in IDLE, then the registered grant.
  - addr_hs_i is ignored.
- Watchdog (TIMEOUT_CYCLES>0):
  - When the counter reaches TIMEOUT_CYCLES-1 without resp_done_i, the next edge gives state=IDLE, grant_o=0, timeout_o=1 for exactly one cycle.
  - rr_ptr keeps its advanced value.
  - If resp_done_i and the expiry coincide, resp_done wins and timeout_o stays 0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1) and the counter saturates; it is not used when TIMEOUT_CYCLES=0.
- Invariants:
  - $onehot0(grant_o) always.
  - grant_o!=0 iff busy_o.
  - grant_o[grant_idx_o]=1 whenever busy_o.
- Fairness: with all requests continuously asserted, every master is granted once per NUM_M transactions.

Decomposition:
- Shared package axi_xbar_pkg contains:
  - the slave address-map constants S0..S5 MIN/MAX: 0x0000_0000-0x0000_3FFF, 0x0001_0000-0x0001_FFFF, 0x0002_0000-0x0002_FFFF, 0x1000_0000-0x1000_03FF, 0x1001_0000-0x1001_03FF, 0x2000_0000-0x207F_FFFF;
  - NUM_SLAVES=6;
  - typedef arb_state_t {IDLE, ADDR, RESP}.
- One sub-module, rr_pick: purely combinational rotating-priority picker.
  - Inputs: req, ptr.
  - Outputs: valid, idx, onehot.
  - It is instantiated once; the FSM, the rr_ptr register and the watchdog live in axi_slave_arbiter.

Test Plan (NUM_M=2, TIMEOUT_CYCLES=8 unless noted):
- Reset: hold ARESETn=0 for 2 edges with req_i=11 -> grant_o=00, grant_idx_o=0, busy_o=0, timeout_o=0; after release, first grant is 01 (rr_ptr=0).
- Single transaction: req_i=01 at cycle 0 -> grant_o=01 at cycle 1; addr_hs_i at cycle 3 -> RESP; resp_done_i at cycle 6 -> grant_o=00, busy_o=0 at cycle 7.
- Fairness: req_i=11 held, each transaction is addr_hs 1 cycle after grant and resp_done 2 cycles later -> grant sequence 01,10,01,10; never two consecutive grants to one master.
- Held grant: req_i goes 01->10 during ADDR -> grant_o stays 01 until addr_hs_i. In RESP, resp_done_i pulsed in IDLE/ADDR before RESP -> ignored, busy_o stays 1.
- Watchdog: grant master 1, addr_hs_i, no resp_done_i -> timeout_o=1 for exactly 1 cycle after 8 RESP cycles and grant_o=00. With req_i=11, the next grant is 01. Repeat with resp_done_i on the expiry cycle -> timeout_o stays 0.
- Reset mid-RESP: ARESETn=0 for 1 edge while grant_o=10 -> all outputs 0 the next cycle, rr_ptr=0. With req_i=11, the next grant is 01.
